// File: rtl/pipe_add_sub.sv
// pipe_add_sub: pipelined two's-complement adder/subtractor.
// The carry chain is cut into CHUNK-bit slices, one slice per stage. Stage k
// adds slice k of A and (B ^ {WIDTH{sub}}) plus the registered carry of stage
// k-1; the operand slices still to be added ride along in shrinking skew
// registers, and the finished low slices of the sum grow stage by stage.
// A single global advance signal stalls every register at once, so the
// handshake is a plain valid/ready with full back-pressure.
// WIDTH must be a positive multiple of CHUNK.
module pipe_add_sub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NSTAGE = WIDTH / CHUNK;

  logic             advance;
  logic [WIDTH-1:0] b_eff;

  // The whole pipe moves only when the output slot is empty or being drained
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Subtraction is A + ~B + 1; the +1 enters as the stage-0 carry-in
  assign b_eff = in_b ^ {WIDTH{in_sub}};

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam int DONE = (k + 1) * CHUNK;
    localparam int REM  = WIDTH - DONE;

    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK-1:0] s_slice;
    logic             cin;
    logic             cout;
    logic             valid_in;
    logic [DONE-1:0]  sum_next;
    logic             valid;
    logic             carry;
    logic [DONE-1:0]  sum;

    if (k == 0) begin : g_head
      assign a_slice  = in_a[CHUNK-1:0];
      assign b_slice  = b_eff[CHUNK-1:0];
      assign cin      = in_sub;
      assign valid_in = in_valid;
      assign sum_next = s_slice;
    end else begin : g_body
      assign a_slice  = g_stage[k-1].g_skew.a_rem[CHUNK-1:0];
      assign b_slice  = g_stage[k-1].g_skew.b_rem[CHUNK-1:0];
      assign cin      = g_stage[k-1].carry;
      assign valid_in = g_stage[k-1].valid;
      assign sum_next = {s_slice, g_stage[k-1].sum};
    end

    assign {cout, s_slice} = {1'b0, a_slice} + {1'b0, b_slice}
                           + {{CHUNK{1'b0}}, cin};

    // Capture this slice's sum and carry together with the entry's valid bit
    always_ff @(posedge clk) begin
      if (rst) begin
        valid <= 1'b0;
      end else if (advance) begin
        valid <= valid_in;
        carry <= cout;
        sum   <= sum_next;
      end
    end

    if (REM > 0) begin : g_skew
      logic [REM-1:0] a_rem;
      logic [REM-1:0] b_rem;
      logic [REM-1:0] a_rem_next;
      logic [REM-1:0] b_rem_next;

      if (k == 0) begin : g_src_in
        assign a_rem_next = in_a[WIDTH-1:DONE];
        assign b_rem_next = b_eff[WIDTH-1:DONE];
      end else begin : g_src_prev
        assign a_rem_next = g_stage[k-1].g_skew.a_rem[REM+CHUNK-1:CHUNK];
        assign b_rem_next = g_stage[k-1].g_skew.b_rem[REM+CHUNK-1:CHUNK];
      end

      // Delay the not-yet-added operand slices so they meet their carry
      always_ff @(posedge clk) begin
        if (advance) begin
          a_rem <= a_rem_next;
          b_rem <= b_rem_next;
        end
      end
    end

    if (k == NSTAGE - 1) begin : g_tail
      logic cmsb;
      logic ovf;

      // Carry into the MSB recovered from the MSB's own sum bit
      assign cmsb = s_slice[CHUNK-1] ^ a_slice[CHUNK-1] ^ b_slice[CHUNK-1];

      // Signed overflow: carry into MSB differs from carry out of MSB
      always_ff @(posedge clk) begin
        if (advance) begin
          ovf <= cmsb ^ cout;
        end
      end
    end
  end

  // Output registers: load only real results so they keep the last one
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
    end else if (advance) begin
      out_valid <= g_stage[NSTAGE-1].valid;
      if (g_stage[NSTAGE-1].valid) begin
        out_sum   <= g_stage[NSTAGE-1].sum;
        out_carry <= g_stage[NSTAGE-1].carry;
        out_ovf   <= g_stage[NSTAGE-1].g_tail.ovf;
        out_zero  <= (g_stage[NSTAGE-1].sum == '0);
      end
    end
  end

endmodule

// File: tb/tb_pipe_add_sub.sv
// tb_pipe_add_sub: bench for pipe_add_sub in three shapes (32/8, 64/16, 16/16).
// Directed corner cases, a stalled stream and a mid-flight reset run on the
// 32/8 instance; all three then take random traffic scored against an
// arithmetic reference model.
module tb_pipe_add_sub;

  typedef struct packed {
    logic [63:0] sum;
    logic        carry;
    logic        ovf;
    logic        zero;
  } exp_t;

  localparam int W [3] = '{32, 64, 16};
  localparam int NOPS = 10000;

  logic        clk;
  logic        rst;
  logic [2:0]  vld;
  logic [2:0]  irdy;
  logic [2:0]  rdy;
  logic [2:0]  ov;
  logic [2:0]  oc;
  logic [2:0]  oo;
  logic [2:0]  oz;
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic        sub_in;
  logic [31:0] sum32;
  logic [63:0] sum64;
  logic [15:0] sum16;
  logic [63:0] osum [3];

  int   total;
  int   bad;
  int   acc [3];
  int   res [3];
  exp_t sb [3][$];

  assign osum[0] = {32'b0, sum32};
  assign osum[1] = sum64;
  assign osum[2] = {48'b0, sum16};

  pipe_add_sub #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(irdy[0]),
    .in_a(a_in[31:0]), .in_b(b_in[31:0]), .in_sub(sub_in),
    .out_valid(ov[0]), .out_ready(rdy[0]), .out_sum(sum32),
    .out_carry(oc[0]), .out_ovf(oo[0]), .out_zero(oz[0])
  );

  pipe_add_sub #(.WIDTH(64), .CHUNK(16)) dut64 (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(irdy[1]),
    .in_a(a_in), .in_b(b_in), .in_sub(sub_in),
    .out_valid(ov[1]), .out_ready(rdy[1]), .out_sum(sum64),
    .out_carry(oc[1]), .out_ovf(oo[1]), .out_zero(oz[1])
  );

  pipe_add_sub #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(irdy[2]),
    .in_a(a_in[15:0]), .in_b(b_in[15:0]), .in_sub(sub_in),
    .out_valid(ov[2]), .out_ready(rdy[2]), .out_sum(sum16),
    .out_carry(oc[2]), .out_ovf(oo[2]), .out_zero(oz[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain w-bit arithmetic, signed overflow from operand/result signs
  function automatic exp_t model(input int w, input logic [63:0] a,
                                 input logic [63:0] b, input logic sub);
    exp_t        e;
    logic [63:0] mask;
    logic [64:0] full;
    logic        sa;
    logic        sbit;
    logic        sr;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    a = a & mask;
    b = b & mask;
    if (!sub) begin
      full    = {1'b0, a} + {1'b0, b};
      e.sum   = full[63:0] & mask;
      e.carry = full[w];
    end else begin
      e.sum   = (a - b) & mask;
      e.carry = (a >= b);
    end
    sa   = a[w-1];
    sbit = b[w-1];
    sr   = e.sum[w-1];
    e.ovf  = sub ? ((sa != sbit) && (sr != sa)) : ((sa == sbit) && (sr != sa));
    e.zero = (e.sum == 64'd0);
    return e;
  endfunction

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      1:       v = 64'd0;
      2:       v = 64'd1 << $urandom_range(0, 63);
      3:       v = ~(64'd1 << $urandom_range(0, 63));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Settle, then score every output transfer and record every accept
  task automatic tick();
    exp_t e;
    #1;
    for (int d = 0; d < 3; d++) begin
      if (ov[d] && rdy[d]) begin
        res[d]++;
        total++;
        assert (sb[d].size() != 0)
        else begin
          bad++;
          $error("FAIL d%0d spurious: observed=result expected=none", d);
        end
        if (sb[d].size() != 0) begin
          e = sb[d].pop_front();
          check($sformatf("d%0d sum", d), osum[d], e.sum);
          check($sformatf("d%0d carry", d), 64'(oc[d]), 64'(e.carry));
          check($sformatf("d%0d ovf", d), 64'(oo[d]), 64'(e.ovf));
          check($sformatf("d%0d zero", d), 64'(oz[d]), 64'(e.zero));
        end
      end
      if (vld[d] && irdy[d]) begin
        sb[d].push_back(model(W[d], a_in, b_in, sub_in));
        acc[d]++;
      end
    end
  endtask

  // One op through the 32/8 instance, result expected exactly 4 edges later
  task automatic run_single(input logic [31:0] a, input logic [31:0] b, input logic sub,
                            input logic [31:0] es, input logic ec, input logic eo,
                            input logic ez, input string tag);
    @(negedge clk);
    a_in   = {32'b0, a};
    b_in   = {32'b0, b};
    sub_in = sub;
    vld[0] = 1'b1;
    rdy[0] = 1'b1;
    #1 check({tag, " in_ready"}, 64'(irdy[0]), 64'd1);
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, " early"}, 64'(ov[0]), 64'd0);
    @(negedge clk);
    check({tag, " valid"}, 64'(ov[0]), 64'd1);
    check({tag, " sum"}, osum[0], {32'b0, es});
    check({tag, " carry"}, 64'(oc[0]), 64'(ec));
    check({tag, " ovf"}, 64'(oo[0]), 64'(eo));
    check({tag, " zero"}, 64'(oz[0]), 64'(ez));
  endtask

  initial begin
    int          idx;
    int          stall;
    int          start;
    int          cyc;
    bit          seen;
    bit          all_done;
    logic [63:0] snap_sum;
    logic        snap_c;

    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    vld    = 3'b000;
    rdy    = 3'b111;
    a_in   = '0;
    b_in   = '0;
    sub_in = 1'b0;
    for (int d = 0; d < 3; d++) begin
      acc[d] = 0;
      res[d] = 0;
    end

    // Reset state of all three shapes
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("d%0d rst out_valid", d), 64'(ov[d]), 64'd0);
      check($sformatf("d%0d rst sum", d), osum[d], 64'd0);
      check($sformatf("d%0d rst carry", d), 64'(oc[d]), 64'd0);
      check($sformatf("d%0d rst ovf", d), 64'(oo[d]), 64'd0);
      check($sformatf("d%0d rst zero", d), 64'(oz[d]), 64'd0);
      check($sformatf("d%0d rst in_ready", d), 64'(irdy[d]), 64'd1);
    end

    // Directed corner cases
    run_single(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "add_wrap");
    run_single(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, "sub_neg");
    run_single(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "add_ovf");
    run_single(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, "sub_ovf");
    repeat (2) @(negedge clk);

    // Stream of 8 ops with a 5-cycle stall at the first result
    idx   = 0;
    stall = 0;
    seen  = 1'b0;
    start = res[0];
    snap_sum = '0;
    snap_c   = 1'b0;
    for (cyc = 0; cyc < 80 && (res[0] - start) < 8; cyc++) begin
      @(negedge clk);
      if (ov[0] && !seen) begin
        seen     = 1'b1;
        stall    = 5;
        snap_sum = osum[0];
        snap_c   = oc[0];
      end
      rdy[0] = (stall == 0);
      vld[0] = (idx < 8);
      a_in   = 64'(idx);
      b_in   = 64'(idx) * 64'h100;
      sub_in = idx[0];
      tick();
      if (stall > 0) begin
        check("stall in_ready", 64'(irdy[0]), 64'd0);
        check("stall valid", 64'(ov[0]), 64'd1);
        check("stall sum", osum[0], snap_sum);
        check("stall carry", 64'(oc[0]), 64'(snap_c));
        stall--;
      end
      if (vld[0] && irdy[0]) idx++;
    end
    check("stream count", 64'(res[0] - start), 64'd8);
    vld[0] = 1'b0;
    rdy[0] = 1'b1;
    repeat (2) @(negedge clk);

    // Reset with three ops in flight: none may come out
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vld[0] = 1'b1;
      a_in   = pick();
      b_in   = pick();
      sub_in = 1'($urandom_range(0, 1));
      tick();
    end
    @(negedge clk);
    vld[0] = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) sb[d].delete();
    #1;
    check("midrst out_valid", 64'(ov[0]), 64'd0);
    check("midrst sum", osum[0], 64'd0);
    check("midrst carry", 64'(oc[0]), 64'd0);
    check("midrst ovf", 64'(oo[0]), 64'd0);
    check("midrst zero", 64'(oz[0]), 64'd0);
    check("midrst in_ready", 64'(irdy[0]), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tick();
      check("midrst silent", 64'(ov[0]), 64'd0);
    end

    // Random traffic on all three shapes
    for (int d = 0; d < 3; d++) begin
      acc[d] = 0;
      res[d] = 0;
    end
    all_done = 1'b0;
    for (cyc = 0; cyc < 40000 && !all_done; cyc++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        vld[d] = (acc[d] < NOPS) && ($urandom_range(0, 3) != 0);
        rdy[d] = ($urandom_range(0, 3) != 0);
      end
      a_in   = pick();
      b_in   = pick();
      sub_in = 1'($urandom_range(0, 1));
      tick();
      all_done = (acc[0] >= NOPS) && (acc[1] >= NOPS) && (acc[2] >= NOPS);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vld = 3'b000;
      rdy = 3'b111;
      tick();
    end
    for (int d = 0; d < 3; d++) begin
      check($sformatf("d%0d accepted", d), 64'(acc[d]), 64'(NOPS));
      check($sformatf("d%0d results", d), 64'(res[d]), 64'(acc[d]));
      check($sformatf("d%0d leftover", d), 64'(sb[d].size()), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_add_sub.md
# pipe_add_sub

Parametrised, pipelined two's-complement adder/subtractor that replaces the single-cycle 32-bit adder in the ALU datapath when wider operands or higher clock rates are needed. The carry chain is split into CHUNK-bit slices, one slice per pipeline stage, with operand skew registers so each stage adds one slice plus the registered carry from the stage before. A valid/ready handshake with full back-pressure sits on both sides, and the block reports carry/borrow, signed overflow and zero flags with the result.

## Interface
- WIDTH, 32, operand/result width in bits; must be a positive multiple of CHUNK.
- CHUNK, 8, bits added per pipeline stage; NSTAGE = WIDTH/CHUNK (≥1).
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode valid this cycle.
- in_ready  output  1  block accepts the input this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_sub  input  1  0: A+B; 1: A−B (computed as A + ~B + 1).
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  downstream consumes the result this cycle.
- out_sum  output  WIDTH  result, modulo 2^WIDTH.
- out_carry  output  1  carry out of bit WIDTH−1 (for subtract: 1 = no borrow, i.e. A ≥ B unsigned).
- out_ovf  output  1  signed overflow.
- out_zero  output  1  out_sum == 0.

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Stage k (0..NSTAGE−1) adds slice k, bits [k·CHUNK +: CHUNK], of A and (B ^ {WIDTH{sub}}). Carry-in is sub for stage 0 and the registered carry from stage k−1 otherwise.
- Skew: slice k of A, B and the sub bit wait k cycles in delay registers before stage k uses them. Result slices produced earlier are carried forward with the entry.
- Each stage holds a valid bit. The entry in the last stage drives the out_* registers.
- Flags are computed in the last stage. out_carry is the carry out of the MSB. out_ovf = carry into MSB XOR carry out of MSB. out_zero is set when the full assembled sum is 0.
- Global stall: advance = !out_valid || out_ready; in_ready = advance. When advance = 0, every stage register, valid bit and output holds its value. When advance = 1, all stages shift by one; a stage with no entry shifting in takes valid = 0.
- Results leave in acceptance order. No entry is lost or duplicated. Bubbles are allowed.
- in_ready does not depend on in_valid. It does depend combinationally on out_ready.

## Timing
- Latency is NSTAGE cycles. An operand accepted at edge n appears with out_valid = 1 after edge n+NSTAGE, provided no stall occurs in between. Each stall cycle adds one cycle.
- Throughput is one operation per cycle when out_ready is held high.
- Reset: on any edge with rst = 1, every valid bit clears, out_valid = 0, out_sum = 0, out_carry = 0, out_ovf = 0 and out_zero = 0. The cycle after reset, in_ready = 1.
- Reset mid-operation discards all in-flight entries; none of them appear at the output. Reset takes priority over simultaneous in/out transfers.
- When out_ready = 0 and out_valid = 1, out_* stay stable until the transfer.
- Simultaneous accept and emit in the same cycle is legal and keeps the pipeline full.
- NSTAGE = 1 gives one register stage: latency 1, same handshake rules.
- The data registers of stages whose valid bit is 0 are don't-care internally. The out_* ports must read 0 only after reset; after that they hold the last result.

## Test plan
- WIDTH=32, CHUNK=8. Add 0xFFFFFFFF + 0x00000001 -> exactly 4 cycles later: out_sum=0x00000000, carry=1, ovf=0, zero=1. This checks carry propagation through all stage boundaries.
- Sub 0x00000005 − 0x00000007 -> 0xFFFFFFFE, carry=0, ovf=0, zero=0.
- Add 0x7FFFFFFF + 0x00000001 -> 0x80000000, carry=0, ovf=1. Sub 0x80000000 − 0x00000001 -> 0x7FFFFFFF, carry=1, ovf=1.
- Stream 8 back-to-back ops (A=i, B=0x100·i, alternating add/sub) with out_ready=0 for 5 cycles after the first out_valid -> in_ready=0 during the stall, outputs held stable, and all 8 results appear in order with correct values.
- Fill the pipe with 3 ops, assert rst for 1 cycle -> out_valid=0 and all outputs 0 the next cycle, in_ready=1, and none of the 3 results ever appear.
- Randomised 10k ops with random in_valid/out_ready, checked against a reference model, for WIDTH/CHUNK = 32/8, 64/16 and 16/16 -> zero mismatches, and the result count equals the accept count.
